// File: rtl/axi_4_slave_burst_ctrl.sv
// AXI4 slave burst controller: accepts one read or write burst at a time,
// generates FIXED/INCR/WRAP beat addresses and drives a req/ack memory port.
module axi_4_slave_burst_ctrl #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ID_WIDTH   = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    m_arvalid,
   input  logic [ADDR_WIDTH-1:0]   m_araddr,
   input  logic [7:0]              m_arlen,
   input  logic [2:0]              m_arsize,
   input  logic [1:0]              m_arburst,
   input  logic [ID_WIDTH-1:0]     m_arid,
   output logic                    s_arready,
   output logic                    s_rvalid,
   output logic [DATA_WIDTH-1:0]   s_rdata,
   output logic [ID_WIDTH-1:0]     s_rid,
   output logic [1:0]              s_rresp,
   output logic                    s_rlast,
   input  logic                    m_rready,
   input  logic                    m_awvalid,
   input  logic [ADDR_WIDTH-1:0]   m_awaddr,
   input  logic [7:0]              m_awlen,
   input  logic [2:0]              m_awsize,
   input  logic [1:0]              m_awburst,
   input  logic [ID_WIDTH-1:0]     m_awid,
   output logic                    s_awready,
   input  logic                    m_wvalid,
   input  logic [DATA_WIDTH-1:0]   m_wdata,
   input  logic [DATA_WIDTH/8-1:0] m_wstrb,
   input  logic                    m_wlast,
   output logic                    s_wready,
   output logic                    s_bvalid,
   output logic [ID_WIDTH-1:0]     s_bid,
   output logic [1:0]              s_bresp,
   input  logic                    m_bready,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_wstrb,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   input  logic                    mem_ack
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned MAX_SIZE   = $clog2(STRB_WIDTH);
   localparam logic [1:0]  BURST_INCR = 2'b01;
   localparam logic [1:0]  BURST_WRAP = 2'b10;
   localparam logic [1:0]  RESP_OKAY  = 2'b00;
   localparam logic [1:0]  RESP_SLV   = 2'b10;

   typedef enum logic [2:0] {IDLE, RD_MEM, RD_RESP, WR_DATA, WR_MEM, WR_RESP} state_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [7:0]            len;
      logic [2:0]            size;
      logic [1:0]            burst;
      logic [ID_WIDTH-1:0]   id;
   } burst_t;

   state_t                state_q, state_d;
   burst_t                cur_q, req_c;
   logic [7:0]            beat_q;
   logic                  err_acc_q, err_wlast_q, wr_prio_q;
   logic [DATA_WIDTH-1:0] rdata_q, wdata_q;
   logic [STRB_WIDTH-1:0] wstrb_q;
   logic                  ar_grant, aw_grant, req_err_c, last_c;
   logic [ADDR_WIDTH-1:0] step_c, wmask_c, next_addr_c;

   function automatic logic burst_err(input burst_t b);
      logic [ADDR_WIDTH-1:0] step_m1;
      step_m1   = (ADDR_WIDTH'(1) << b.size) - ADDR_WIDTH'(1);
      burst_err = (b.burst == 2'b11) || (32'(b.size) > MAX_SIZE) ||
                  ((b.burst == BURST_WRAP) && !(b.len inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
                  ((b.burst == BURST_WRAP) && ((b.addr & step_m1) != '0));
   endfunction

   // Round-robin arbitration; wr_prio_q is set after a read grant
   always_comb begin
      ar_grant = 1'b0;
      aw_grant = 1'b0;
      if (!reset && state_q == IDLE) begin
         ar_grant = m_arvalid && (!m_awvalid || !wr_prio_q);
         aw_grant = m_awvalid && (!m_arvalid || wr_prio_q);
      end
   end

   assign s_arready = ar_grant;
   assign s_awready = aw_grant;

   always_comb begin
      req_c = '0;
      if (ar_grant) req_c = '{addr: m_araddr, len: m_arlen, size: m_arsize, burst: m_arburst, id: m_arid};
      else          req_c = '{addr: m_awaddr, len: m_awlen, size: m_awsize, burst: m_awburst, id: m_awid};
      req_err_c = burst_err(req_c);
   end

   assign last_c = (beat_q == cur_q.len);

   // Beat address generator
   always_comb begin
      step_c      = ADDR_WIDTH'(1) << cur_q.size;
      wmask_c     = ((ADDR_WIDTH'(cur_q.len) + ADDR_WIDTH'(1)) << cur_q.size) - ADDR_WIDTH'(1);
      next_addr_c = cur_q.addr;
      if (cur_q.burst == BURST_INCR)
         next_addr_c = (cur_q.addr & ~(step_c - ADDR_WIDTH'(1))) + step_c;
      else if (cur_q.burst == BURST_WRAP)
         next_addr_c = (cur_q.addr & ~wmask_c) | ((cur_q.addr + step_c) & wmask_c);
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (ar_grant)      state_d = req_err_c ? RD_RESP : RD_MEM;
            else if (aw_grant) state_d = WR_DATA;
         end
         RD_MEM:  if (mem_ack) state_d = RD_RESP;
         RD_RESP: begin
            if (m_rready) begin
               if (last_c)         state_d = IDLE;
               else if (!err_acc_q) state_d = RD_MEM;
            end
         end
         WR_DATA: begin
            if (m_wvalid) begin
               if (!err_acc_q) state_d = WR_MEM;
               else if (last_c) state_d = WR_RESP;
            end
         end
         WR_MEM:  if (mem_ack) state_d = last_c ? WR_RESP : WR_DATA;
         WR_RESP: if (m_bready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      s_rvalid = 1'b0;
      s_rdata  = '0;
      s_rid    = '0;
      s_rresp  = RESP_OKAY;
      s_rlast  = 1'b0;
      s_wready = 1'b0;
      s_bvalid = 1'b0;
      s_bid    = '0;
      s_bresp  = RESP_OKAY;
      case (state_q)
         RD_MEM:  mem_req = 1'b1;
         RD_RESP: begin
            s_rvalid = 1'b1;
            s_rdata  = rdata_q;
            s_rid    = cur_q.id;
            s_rresp  = err_acc_q ? RESP_SLV : RESP_OKAY;
            s_rlast  = last_c;
         end
         WR_DATA: s_wready = 1'b1;
         WR_MEM: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
         end
         WR_RESP: begin
            s_bvalid = 1'b1;
            s_bid    = cur_q.id;
            s_bresp  = (err_acc_q || err_wlast_q) ? RESP_SLV : RESP_OKAY;
         end
         default: ;
      endcase
   end

   assign mem_addr  = cur_q.addr;
   assign mem_wdata = wdata_q;
   assign mem_wstrb = wstrb_q;

   // Burst context, beat counter and data holding registers
   always_ff @(posedge clk) begin
      if (reset) begin
         cur_q       <= '0;
         beat_q      <= '0;
         err_acc_q   <= 1'b0;
         err_wlast_q <= 1'b0;
         wr_prio_q   <= 1'b0;
         rdata_q     <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ar_grant || aw_grant) begin
                  cur_q       <= req_c;
                  beat_q      <= '0;
                  err_acc_q   <= req_err_c;
                  err_wlast_q <= 1'b0;
                  wr_prio_q   <= ar_grant;
                  rdata_q     <= '0;
               end
            end
            RD_MEM: if (mem_ack) rdata_q <= mem_rdata;
            RD_RESP: begin
               if (m_rready && !last_c) begin
                  beat_q     <= beat_q + 8'd1;
                  cur_q.addr <= next_addr_c;
               end
            end
            WR_DATA: begin
               if (m_wvalid) begin
                  if (!err_acc_q) begin
                     wdata_q <= m_wdata;
                     wstrb_q <= m_wstrb;
                  end
                  if (m_wlast != last_c) err_wlast_q <= 1'b1;
                  if (err_acc_q && !last_c) begin
                     beat_q     <= beat_q + 8'd1;
                     cur_q.addr <= next_addr_c;
                  end
               end
            end
            WR_MEM: begin
               if (mem_ack && !last_c) begin
                  beat_q     <= beat_q + 8'd1;
                  cur_q.addr <= next_addr_c;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
